// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: owns the PC, drives a single-outstanding req/ack
// memory port and holds one fetched instruction for the IF/ID register.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_i,
  input  logic        hazard_i,
  input  logic        flush_i,
  input  logic [31:0] branch_target_i,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_data_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o,
  output logic        valid_o,
  output logic [31:0] bubble_cnt_o
);

  typedef enum logic {BOOT, RUN} state_t;

  state_t      state, state_nx;
  logic [31:0] pc, pc_nx;
  logic [31:0] buf_pc, buf_pc_nx;
  logic [31:0] buf_inst, buf_inst_nx;
  logic [31:0] redir_target, redir_target_nx;
  logic [31:0] bubble_cnt, bubble_cnt_nx;
  logic        buf_valid, buf_valid_nx;
  logic        redir_pending, redir_pending_nx;
  logic        accept, free, ack;
  logic [31:0] flush_target;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state         <= BOOT;
      pc            <= RESET_PC;
      buf_valid     <= 1'b0;
      buf_pc        <= 32'd0;
      buf_inst      <= 32'd0;
      redir_pending <= 1'b0;
      redir_target  <= 32'd0;
      bubble_cnt    <= 32'd0;
    end else begin
      state         <= state_nx;
      pc            <= pc_nx;
      buf_valid     <= buf_valid_nx;
      buf_pc        <= buf_pc_nx;
      buf_inst      <= buf_inst_nx;
      redir_pending <= redir_pending_nx;
      redir_target  <= redir_target_nx;
      bubble_cnt    <= bubble_cnt_nx;
    end
  end

  always_comb begin
    accept           = !stall_i && !hazard_i;
    free             = !buf_valid || accept;
    mem_req_o        = (state == RUN) && free;
    ack              = mem_req_o && mem_ack_i;
    flush_target     = branch_target_i & ~32'h3;

    state_nx         = RUN;
    pc_nx            = pc;
    buf_valid_nx     = buf_valid;
    buf_pc_nx        = buf_pc;
    buf_inst_nx      = buf_inst;
    redir_pending_nx = redir_pending;
    redir_target_nx  = redir_target;
    bubble_cnt_nx    = bubble_cnt;

    if (flush_i) begin
      buf_valid_nx = 1'b0;
      if (!mem_req_o || ack) begin
        // Nothing in flight: redirect now and drop any same-cycle ack data.
        pc_nx            = flush_target;
        redir_pending_nx = 1'b0;
      end else begin
        // Request in flight must complete at its address; redirect on its ack.
        redir_pending_nx = 1'b1;
        redir_target_nx  = flush_target;
      end
    end else if (ack) begin
      if (redir_pending) begin
        pc_nx            = redir_target;
        redir_pending_nx = 1'b0;
        buf_valid_nx     = 1'b0;
      end else begin
        buf_pc_nx    = pc;
        buf_inst_nx  = mem_data_i;
        buf_valid_nx = 1'b1;
        pc_nx        = pc + 32'd4;
      end
    end else if (accept) begin
      buf_valid_nx = 1'b0;
    end

    if (state == RUN && !buf_valid) begin
      bubble_cnt_nx = bubble_cnt + 32'd1;
    end
  end

  assign mem_addr_o   = pc;
  assign pc_o         = buf_pc;
  assign inst_o       = buf_valid ? buf_inst : NOP_INST;
  assign valid_o      = buf_valid;
  assign bubble_cnt_o = bubble_cnt;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit with a behavioural instruction memory whose
// ack arrives after a selectable number of wait cycles; data = addr ^ A5A5_0000.
module tb_if_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0000;
  localparam logic [31:0] XK  = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        hazard = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] target = 32'd0;
  logic        mem_ack;
  logic [31:0] mem_data;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] pc_o;
  logic [31:0] inst_o;
  logic        valid_o;
  logic [31:0] bubble_cnt;

  logic        force_ack = 1'b0;
  int          ws = 0;
  int          wait_cnt = 0;
  int          n_assert = 0;
  int          n_fail = 0;

  if_fetch_unit dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .stall_i        (stall),
    .hazard_i       (hazard),
    .flush_i        (flush),
    .branch_target_i(target),
    .mem_ack_i      (mem_ack),
    .mem_data_i     (mem_data),
    .mem_req_o      (mem_req),
    .mem_addr_o     (mem_addr),
    .pc_o           (pc_o),
    .inst_o         (inst_o),
    .valid_o        (valid_o),
    .bubble_cnt_o   (bubble_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst || !mem_req || mem_ack) wait_cnt <= 0;
    else                            wait_cnt <= wait_cnt + 1;
  end

  assign mem_ack  = force_ack | (mem_req && (wait_cnt >= ws));
  assign mem_data = mem_addr ^ XK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; stall = 1'b0; hazard = 1'b0; flush = 1'b0; force_ack = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  task automatic wait_valid_pc(input logic [31:0] addr, input string tag);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      if (valid_o && pc_o == addr) found = 1'b1;
    end
    check(tag, 32'(found), 32'd1);
  endtask

  initial begin
    // Zero-wait memory: one instruction per cycle.
    ws = 0;
    do_reset();
    check("rst_req",    32'(mem_req), 32'd0);
    check("rst_pc",     pc_o, 32'd0);
    check("rst_inst",   inst_o, NOP);
    check("rst_valid",  32'(valid_o), 32'd0);
    check("rst_bubble", bubble_cnt, 32'd0);
    tick();
    check("zw_req0",    32'(mem_req), 32'd1);
    check("zw_addr0",   mem_addr, 32'd0);
    check("zw_valid0",  32'(valid_o), 32'd0);
    tick();
    check("zw_valid1",  32'(valid_o), 32'd1);
    check("zw_pc1",     pc_o, 32'd0);
    check("zw_inst1",   inst_o, 32'hA5A5_0000);
    tick();
    check("zw_pc2",     pc_o, 32'd4);
    check("zw_inst2",   inst_o, 32'hA5A5_0004);
    check("zw_bubble",  bubble_cnt, 32'd1);
    tick();
    check("zw_pc3",     pc_o, 32'd8);
    check("zw_inst3",   inst_o, 32'hA5A5_0008);

    // 3-cycle memory, 4-cycle stall holding pc 8.
    ws = 2;
    do_reset();
    wait_valid_pc(32'd0, "lat_first");
    check("lat_bubble", bubble_cnt, 32'd3);
    wait_valid_pc(32'd8, "lat_pc8");
    check("lat_inst8",  inst_o, 32'hA5A5_0008);
    stall = 1'b1;
    #1;
    check("stall_req",  32'(mem_req), 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("stall_pc",    pc_o, 32'd8);
      check("stall_inst",  inst_o, 32'hA5A5_0008);
      check("stall_noreq", 32'(mem_req), 32'd0);
    end
    stall = 1'b0;
    #1;
    check("acc_req",    32'(mem_req), 32'd1);
    check("acc_addr",   mem_addr, 32'd12);
    tick();
    check("acc_valid",  32'(valid_o), 32'd0);

    // Flush with no request in flight (buffer held by stall).
    do_reset();
    wait_valid_pc(32'd4, "fl_pc4");
    stall = 1'b1; flush = 1'b1; target = 32'h100;
    #1;
    check("fl_noreq",   32'(mem_req), 32'd0);
    tick();
    stall = 1'b0; flush = 1'b0;
    #1;
    check("fl_valid",   32'(valid_o), 32'd0);
    check("fl_nop",     inst_o, NOP);
    check("fl_req",     32'(mem_req), 32'd1);
    check("fl_addr",    mem_addr, 32'h100);
    tick();
    check("fl_nop2",    inst_o, NOP);
    wait_valid_pc(32'h100, "fl_pc100");
    check("fl_inst100", inst_o, 32'hA5A5_0100);

    // Two flushes while the request for 8 is in flight.
    do_reset();
    wait_valid_pc(32'd4, "pend_pc4");
    flush = 1'b1; target = 32'h200;
    #1;
    check("pend_req",   32'(mem_req), 32'd1);
    check("pend_addr",  mem_addr, 32'd8);
    tick();
    target = 32'h300;
    #1;
    check("pend_valid", 32'(valid_o), 32'd0);
    check("pend_hold",  mem_addr, 32'd8);
    tick();
    flush = 1'b0;
    #1;
    check("pend_ack",   32'(mem_ack), 32'd1);
    check("pend_hold2", mem_addr, 32'd8);
    tick();
    check("pend_drop",  32'(valid_o), 32'd0);
    check("pend_req2",  32'(mem_req), 32'd1);
    check("pend_addr2", mem_addr, 32'h300);
    wait_valid_pc(32'h300, "pend_pc300");
    check("pend_inst",  inst_o, 32'hA5A5_0300);

    // Flush coinciding with an ack; target low bits are dropped.
    ws = 0;
    do_reset();
    tick();
    flush = 1'b1; target = 32'h41;
    tick();
    flush = 1'b0;
    #1;
    check("fa_valid",   32'(valid_o), 32'd0);
    check("fa_nop",     inst_o, NOP);
    check("fa_addr",    mem_addr, 32'h40);
    tick();
    check("fa_pc",      pc_o, 32'h40);
    check("fa_inst",    inst_o, 32'hA5A5_0040);

    // Reset mid-wait with stall high, then a stale ack.
    ws = 2;
    do_reset();
    wait_valid_pc(32'd4, "mr_pc4");
    tick();
    stall = 1'b1; rst = 1'b1;
    #1;
    check("mr_inflight", mem_addr, 32'd8);
    tick();
    check("mr_req",     32'(mem_req), 32'd0);
    check("mr_pc",      pc_o, 32'd0);
    check("mr_inst",    inst_o, NOP);
    check("mr_valid",   32'(valid_o), 32'd0);
    check("mr_bubble",  bubble_cnt, 32'd0);
    rst = 1'b0; force_ack = 1'b1;
    tick();
    force_ack = 1'b0;
    #1;
    check("mr_stale",   32'(valid_o), 32'd0);
    check("mr_req2",    32'(mem_req), 32'd1);
    check("mr_addr",    mem_addr, 32'd0);
    check("mr_bub2",    bubble_cnt, 32'd0);
    stall = 1'b0;
    wait_valid_pc(32'd0, "mr_restart");
    check("mr_inst0",   inst_o, 32'hA5A5_0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
